video_timing_tracker: RTL
=========================

VIDEO_TIMING_TRACKER -- requirements
Module: video_timing_tracker

Interface
REQ-001 SHALL have parameter XW, default 12, bit width of column count and measured active width.
REQ-002 SHALL have parameter YW, default 11, bit width of line count and measured active height.
REQ-003 SHALL have parameter LOCK_FRAMES, default 2, number of consecutive matching frames required to assert locked.
REQ-004 SHALL have port pxlClk  input  1  pixel clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port vsync  input  1  vertical sync from polarity-corrected stage, active-high.
REQ-007 SHALL have port hsync  input  1  horizontal sync, polarity-corrected, active-high.
REQ-008 SHALL have port de  input  1  active-pixel qualifier.
REQ-009 SHALL have port pix_in  input  24  RGB888 pixel data.
REQ-010 SHALL have ports vsync_o, hsync_o, de_o  output  1 each  registered sync/de copies.
REQ-011 SHALL have port pix_o  output  24  registered pixel data.
REQ-012 SHALL have port x  output  XW  column index of pixel on pix_o.
REQ-013 SHALL have port y  output  YW  active-line index of pixel on pix_o.
REQ-014 SHALL have ports sof, sol  output  1 each  start-of-frame / start-of-line pulses.
REQ-015 SHALL have ports act_w  output  XW, act_h  output  YW  measured active width/height of last complete frame.
REQ-016 SHALL have port locked  output  1  timing stable indicator.

Function
REQ-017 SHALL delay vsync, hsync, de, pix_in by exactly one pxlClk cycle to vsync_o, hsync_o, de_o, pix_o; x, y, sof, sol SHALL be aligned to that same cycle.
REQ-018 SHALL detect de falling edge (de=0, previous de=1) as end-of-line and vsync rising edge (vsync=1, previous vsync=0) as end-of-frame.
REQ-019 Column counter SHALL start at 0 on first de=1 cycle of a line, increment by 1 per de=1 cycle, saturate at all-ones, clear at end-of-line.
REQ-020 x SHALL present column counter value of the pixel on pix_o; x SHALL hold its last value while de_o=0.
REQ-021 Line counter SHALL increment (saturating) at each end-of-line and clear to 0 at end-of-frame; y SHALL present it.
REQ-022 sol SHALL pulse high for one cycle with the first pixel (x=0) of every active line.
REQ-023 sof SHALL pulse high for one cycle with the first pixel of the first active line after end-of-frame (x=0, y=0), coincident with sol.
REQ-024 At each end-of-line, line width (column count) SHALL be compared with the first line width of the current frame; any mismatch SHALL mark the frame bad.
REQ-025 At end-of-frame, candidate W = first-line width and H = line count SHALL be computed; act_w/act_h SHALL load W/H on the following cycle, regardless of match.
REQ-026 Stability counter SHALL increment (saturating at LOCK_FRAMES) when frame not bad, H>0 and W,H equal previous frame's W,H; otherwise clear to 0.
REQ-027 locked SHALL be 1 exactly when stability counter >= LOCK_FRAMES, updated on the cycle act_w/act_h update.
REQ-028 End-of-line and end-of-frame in the same cycle: line SHALL be counted into H first, then the frame closed.
REQ-029 Frame with no active lines (H=0) SHALL clear stability counter and drive act_w=0, act_h=0.
REQ-030 hsync SHALL only be pipelined; it SHALL NOT affect counting.

Reset
REQ-031 While rst=0 all outputs, counters, edge-history registers and stability counter SHALL be 0; previous-frame W/H SHALL be 0.
REQ-032 First frame after reset release SHALL never assert locked; reset asserted mid-frame SHALL abort measurement, and counting SHALL resume cleanly at next de rising edge.

Verification
REQ-033 Frame 4 lines x 8 pixels, repeated 3 times, LOCK_FRAMES=2 -> act_w=8, act_h=4 after frame 1; locked=0 after frames 1 and 2, locked=1 after frame 3.
REQ-034 Single pixel stream -> pix_o/de_o equal pix_in/de delayed 1 cycle; x runs 0..7, sol at x=0 each line, sof only on line y=0.
REQ-035 Locked stream, then one line of 7 pixels inside a frame -> at that frame end locked=0, stability counter 0; two more clean frames required to relock.
REQ-036 vsync rising coincident with last de falling edge of 4-line frame -> act_h=4, next frame first pixel y=0 with sof=1.
REQ-037 rst pulsed low mid-line -> all outputs 0 during reset; next full frame gives act_w=8, act_h=4, locked=0.
REQ-038 Frame with vsync but no de -> act_w=0, act_h=0, locked=0.

Source files
------------

// File: rtl/video_timing_tracker.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_tracker
// Brief    : Registers the video stream for one cycle, adds pixel coordinates
//            and frame/line markers, and measures the active geometry to
//            decide when the input timing is stable.
// Revision : 1.0
// ============================================================================
module video_timing_tracker #(
    parameter int XW          = 12,
    parameter int YW          = 11,
    parameter int LOCK_FRAMES = 2
) (
    input  logic          pxlClk,
    input  logic          rst,
    input  logic          vsync,
    input  logic          hsync,
    input  logic          de,
    input  logic [23:0]   pix_in,
    output logic          vsync_o,
    output logic          hsync_o,
    output logic          de_o,
    output logic [23:0]   pix_o,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          sof,
    output logic          sol,
    output logic [XW-1:0] act_w,
    output logic [YW-1:0] act_h,
    output logic          locked
);

    localparam int            SW       = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [SW-1:0] LOCK_MAX = SW'(LOCK_FRAMES);
    localparam logic [XW-1:0] COL_MAX  = '1;
    localparam logic [YW-1:0] LINE_MAX = '1;

    logic          vsync_q, vsync_d, hsync_q, hsync_d, de_q, de_d;
    logic [23:0]   pix_q, pix_d;
    logic [XW-1:0] x_q, x_d, col_q, col_d, first_w_q, first_w_d, act_w_q, act_w_d;
    logic [YW-1:0] y_q, y_d, line_q, line_d, act_h_q, act_h_d;
    logic          sof_q, sof_d, sol_q, sol_d, bad_q, bad_d, locked_q, locked_d;
    logic [SW-1:0] stab_q, stab_d;

    logic          eol, eof, first_pix, width_mis, match;
    logic [YW-1:0] line_inc, line_cur, frame_h;
    logic [XW-1:0] frame_w;
    logic          frame_bad;

    // The registered de/vsync copies double as the edge-detect history.
    assign eol       = ~de & de_q;
    assign eof       = vsync & ~vsync_q;
    assign first_pix = de & ~de_q;
    assign line_inc  = (line_q == LINE_MAX) ? line_q : line_q + YW'(1);
    assign line_cur  = eof ? '0 : line_q;
    assign width_mis = (line_q != '0) && (col_q != first_w_q);

    always_comb begin
        vsync_d   = vsync;
        hsync_d   = hsync;
        de_d      = de;
        pix_d     = pix_in;
        x_d       = x_q;
        y_d       = y_q;
        sol_d     = 1'b0;
        sof_d     = 1'b0;
        col_d     = col_q;
        line_d    = line_q;
        first_w_d = first_w_q;
        bad_d     = bad_q;
        act_w_d   = act_w_q;
        act_h_d   = act_h_q;
        stab_d    = stab_q;
        locked_d  = locked_q;
        frame_w   = '0;
        frame_h   = '0;
        frame_bad = 1'b0;
        match     = 1'b0;

        if (de) begin
            x_d   = col_q;
            y_d   = line_cur;
            sol_d = first_pix;
            sof_d = first_pix & (line_cur == '0);
            if (col_q != COL_MAX) begin
                col_d = col_q + XW'(1);
            end
        end

        if (eol) begin
            col_d  = '0;
            line_d = line_inc;
            if (line_q == '0) begin
                first_w_d = col_q;
            end else if (width_mis) begin
                bad_d = 1'b1;
            end
        end

        // A line ending in the same cycle is folded into the frame first.
        if (eof) begin
            frame_h = eol ? line_inc : line_q;
            if (frame_h == '0) begin
                frame_w = '0;
            end else if (eol && (line_q == '0)) begin
                frame_w = col_q;
            end else begin
                frame_w = first_w_q;
            end
            frame_bad = bad_q | (eol & width_mis);
            // act_w/act_h hold the previous frame's geometry until reloaded here.
            match     = ~frame_bad && (frame_h != '0) &&
                        (frame_w == act_w_q) && (frame_h == act_h_q);
            if (!match) begin
                stab_d = '0;
            end else if (stab_q < LOCK_MAX) begin
                stab_d = stab_q + SW'(1);
            end
            locked_d  = (stab_d >= LOCK_MAX);
            act_w_d   = frame_w;
            act_h_d   = frame_h;
            line_d    = '0;
            bad_d     = 1'b0;
            first_w_d = '0;
        end
    end

    always_ff @(posedge pxlClk or negedge rst) begin
        if (!rst) begin
            vsync_q   <= 1'b0;
            hsync_q   <= 1'b0;
            de_q      <= 1'b0;
            pix_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            sof_q     <= 1'b0;
            sol_q     <= 1'b0;
            col_q     <= '0;
            line_q    <= '0;
            first_w_q <= '0;
            bad_q     <= 1'b0;
            act_w_q   <= '0;
            act_h_q   <= '0;
            stab_q    <= '0;
            locked_q  <= 1'b0;
        end else begin
            vsync_q   <= vsync_d;
            hsync_q   <= hsync_d;
            de_q      <= de_d;
            pix_q     <= pix_d;
            x_q       <= x_d;
            y_q       <= y_d;
            sof_q     <= sof_d;
            sol_q     <= sol_d;
            col_q     <= col_d;
            line_q    <= line_d;
            first_w_q <= first_w_d;
            bad_q     <= bad_d;
            act_w_q   <= act_w_d;
            act_h_q   <= act_h_d;
            stab_q    <= stab_d;
            locked_q  <= locked_d;
        end
    end

    assign vsync_o = vsync_q;
    assign hsync_o = hsync_q;
    assign de_o    = de_q;
    assign pix_o   = pix_q;
    assign x       = x_q;
    assign y       = y_q;
    assign sof     = sof_q;
    assign sol     = sol_q;
    assign act_w   = act_w_q;
    assign act_h   = act_h_q;
    assign locked  = locked_q;

endmodule
`default_nettype wire
